uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions for the receiver and transmitter: FSM states, parity and stop-bit codes.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam int   PAR_EN    = 1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Stop-bit field encodes count-1.
    function automatic logic [2:0] stop_bits(input logic [1:0] code);
        return {1'b0, code} + 3'd1;
    endfunction

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic mode);
        logic p;
        p = ^d;
        if (mode == PAR_ODD) p = ~p;
        else if (mode == PAR_EVEN) p = ^d;
        return p;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
// Metastability synchroniser for the serial line plus falling-edge detect.
// Latency: SYNC_STAGES clocks to rxd_s; fall_pulse is combinational from synchronised flops.
// Backpressure: none.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_uart_rxd,
    output logic rxd_s,
    output logic fall_pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '1;
            rxd_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rxd};
            rxd_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s      = sync_q[SYNC_STAGES-1];
    assign fall_pulse = rxd_d & ~rxd_s;
endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receive engine, 8 data bits, optional parity, 1-4 stop bits; UART_RX_MAJORITY_EN enables 2-of-3 voting.
// Latency: o_rx_valid 1 clk after the last stop-bit decision (decision is 1 clk later with voting).
// Backpressure: none; o_rx_valid is a single-cycle pulse and data/flags hold until the next frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_parity,
    input  logic [1:0]  i_stop,
    input  logic [15:0] i_div,
    input  logic        i_rx_en,
    input  logic        i_uart_rxd,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_valid,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_busy
);
    logic                 rxd_s;
    logic                 fall_pulse;
    uart_state_t          state;
    logic [15:0]          clk_cnt;
    logic [15:0]          div_q;
    logic [15:0]          mid;
    logic [1:0]           par_q;
    logic [1:0]           stop_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_cnt;
    logic [2:0]           stop_cnt;
    logic                 par_err;
    logic                 frm_err;
    logic                 bit_tick;
    logic                 bit_val;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_uart_rxd (i_uart_rxd),
        .rxd_s      (rxd_s),
        .fall_pulse (fall_pulse)
    );

    assign mid = div_q >> 1;

`ifdef UART_RX_MAJORITY_EN
    logic smp_a;
    logic smp_b;

    // Votes over mid-1, mid and the live sample at mid+1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            if (clk_cnt == mid - 16'd1) smp_a <= rxd_s;
            if (clk_cnt == mid)         smp_b <= rxd_s;
        end
    end

    assign bit_tick = (clk_cnt == mid + 16'd1);
    assign bit_val  = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);
`else
    assign bit_tick = (clk_cnt == mid);
    assign bit_val  = rxd_s;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            div_q        <= '0;
            par_q        <= '0;
            stop_q       <= '0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else if (!i_rx_en) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            if (state != IDLE) clk_cnt <= (clk_cnt == div_q) ? 16'd0 : clk_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (fall_pulse) begin
                        state   <= START;
                        clk_cnt <= '0;
                        div_q   <= i_div;
                        par_q   <= i_parity;
                        stop_q  <= i_stop;
                        o_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        if (bit_val) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q  <= {bit_val, shift_q[DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        stop_cnt <= '0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) state <= par_q[PAR_EN] ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        par_err <= bit_val ^ parity_bit(shift_q, par_q[0]);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        frm_err <= frm_err | ~bit_val;
                        if (stop_cnt + 3'd1 == stop_bits(stop_q)) begin
                            state        <= DONE;
                            o_rx_valid   <= 1'b1;
                            o_rx_data    <= shift_q;
                            o_parity_err <= par_err;
                            o_frame_err  <= frm_err | ~bit_val;
                        end else begin
                            stop_cnt <= stop_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;
    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [1:0]  parity = 2'b00;
    logic [1:0]  stop   = 2'b00;
    logic [15:0] div    = 16'd15;
    logic        rx_en  = 1'b1;
    logic        rxd    = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, perr, ferr, busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } rec_t;
    rec_t mon_q[$];

    uart_rx #(.SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_parity     (parity),
        .i_stop       (stop),
        .i_div        (div),
        .i_rx_en      (rx_en),
        .i_uart_rxd   (rxd),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rx_valid === 1'b1) mon_q.push_back('{d: rx_data, pe: perr, fe: ferr, c: cyc});

    // Two sync flops + edge detect + state entry, then decision at the middle of the last bit.
    function automatic int exp_cyc(input int c0, input int d, input int nbits);
        return c0 + 4 + (d >> 1) + (nbits - 1) * (d + 1) + MAJ;
    endfunction

    task automatic drive_bit(input logic v, input int d);
        rxd = v;
        repeat (d + 1) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input int nstop,
                              input logic [3:0] sv, input int dv, output int c0);
        c0 = cyc;
        drive_bit(1'b0, dv);
        for (int i = 0; i < 8; i++) drive_bit(d[i], dv);
        if (pen) drive_bit(pbit, dv);
        for (int i = 0; i < nstop; i++) drive_bit(sv[i], dv);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int c0;
        rec_t r;
        mon_q.delete();
        div = 16'd15; parity = 2'b00; stop = 2'b00;
        send_frame(8'hA5, 0, 0, 1, 4'hF, 15, c0);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d want 1", mon_q.size());
        end else begin
            r = mon_q.pop_front();
            checks++; if (r.d !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", r.d); end
            checks++; if (r.pe !== 1'b0 || r.fe !== 1'b0) begin errors++; $display("FAIL basic_flags: got pe=%b fe=%b want 0 0", r.pe, r.fe); end
            checks++; if (r.c != exp_cyc(c0, 15, 10)) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", r.c, exp_cyc(c0, 15, 10)); end
        end
    endtask

    task automatic test_rx_en();
        mon_q.delete();
        drive_bit(1'b0, 15);
        drive_bit(1'b1, 15);
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rxen_busy: got %b want 0", busy); end
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        rx_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL rxen_pulse: got %0d pulses want 0", mon_q.size()); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL rxen_hold: got %h want a5", rx_data); end
    endtask

    task automatic test_parity();
        int c0;
        rec_t r;
        parity = 2'b10; stop = 2'b00; div = 16'd15;
        for (int pb = 0; pb < 2; pb++) begin
            mon_q.delete();
            send_frame(8'h03, 1, pb[0], 1, 4'hF, 15, c0);
            repeat (40) @(posedge clk);
            #1;
            checks++;
            if (mon_q.size() != 1) begin
                errors++; $display("FAIL parity_count: pbit=%0d got %0d want 1", pb, mon_q.size());
            end else begin
                r = mon_q.pop_front();
                checks++; if (r.d !== 8'h03) begin errors++; $display("FAIL parity_data: got %h want 03", r.d); end
                checks++; if (r.pe !== pb[0]) begin errors++; $display("FAIL parity_err: pbit=%0d got %b want %b", pb, r.pe, pb[0]); end
            end
        end
    endtask

    task automatic test_odd_frame();
        int c0;
        rec_t r;
        mon_q.delete();
        parity = 2'b11; stop = 2'd3; div = 16'd15;
        send_frame(8'h00, 1, 1, 4, 4'b1011, 15, c0);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 1) begin
            errors++; $display("FAIL odd_count: got %0d want 1", mon_q.size());
        end else begin
            r = mon_q.pop_front();
            checks++; if (r.fe !== 1'b1 || r.pe !== 1'b0) begin errors++; $display("FAIL odd_flags: got pe=%b fe=%b want 0 1", r.pe, r.fe); end
            checks++; if (r.c != exp_cyc(c0, 15, 14)) begin errors++; $display("FAIL odd_latency: got %0d want %0d", r.c, exp_cyc(c0, 15, 14)); end
        end
    endtask

    task automatic test_glitch();
        mon_q.delete();
        div = 16'd15; parity = 2'b00; stop = 2'b00;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
        repeat (40) @(posedge clk);
        #1;
        checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL glitch_pulse: got %0d want 0", mon_q.size()); end
    endtask

    // One-clock low spike aligned to the mid sample of data bit 3 of 8'hFF.
    task automatic test_spike();
        logic [7:0] want;
        want = (MAJ == 1) ? 8'hFF : 8'hF7;
        mon_q.delete();
        div = 16'd15; parity = 2'b00; stop = 2'b00;
        drive_bit(1'b0, 15);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rxd = 1'b1;
                repeat (8) @(posedge clk);
                #1; rxd = 1'b0;
                @(posedge clk);
                #1; rxd = 1'b1;
                repeat (7) @(posedge clk);
                #1;
            end else begin
                drive_bit(1'b1, 15);
            end
        end
        drive_bit(1'b1, 15);
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 1) begin
            errors++; $display("FAIL spike_count: got %0d want 1", mon_q.size());
        end else begin
            checks++; if (mon_q[0].d !== want) begin errors++; $display("FAIL spike_data: got %h want %h", mon_q[0].d, want); end
        end
    endtask

    task automatic test_back_to_back();
        int ca, cb;
        mon_q.delete();
        div = 16'd15; parity = 2'b00; stop = 2'b00;
        send_frame(8'h55, 0, 0, 1, 4'hF, 15, ca);
        send_frame(8'hAA, 0, 0, 1, 4'hF, 15, cb);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", mon_q.size());
        end else begin
            checks++; if (mon_q[0].d !== 8'h55) begin errors++; $display("FAIL b2b_data0: got %h want 55", mon_q[0].d); end
            checks++; if (mon_q[1].d !== 8'hAA) begin errors++; $display("FAIL b2b_data1: got %h want aa", mon_q[1].d); end
            checks++; if (mon_q[1].c != exp_cyc(cb, 15, 10)) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", mon_q[1].c, exp_cyc(cb, 15, 10)); end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        mon_q.delete();
        div = 16'd15; parity = 2'b00; stop = 2'b00;
        drive_bit(1'b0, 15);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 15);
        rxd = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got busy=%b vld=%b want 0 0", busy, rx_valid); end
        checks++; if (perr !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got pe=%b fe=%b want 0 0", perr, ferr); end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL rstmid_pulse: got %0d want 0", mon_q.size()); end
        send_frame(8'h3C, 0, 0, 1, 4'hF, 15, c0);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 1) begin
            errors++; $display("FAIL rstmid_count: got %0d want 1", mon_q.size());
        end else begin
            checks++; if (mon_q[0].d !== 8'h3C) begin errors++; $display("FAIL rstmid_next: got %h want 3c", mon_q[0].d); end
        end
    endtask

    task automatic test_break();
        int c0;
        mon_q.delete();
        div = 16'd15; parity = 2'b00; stop = 2'b00;
        send_frame(8'h00, 0, 0, 1, 4'h0, 15, c0);
        repeat (300) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 1) begin
            errors++; $display("FAIL break_count: got %0d want 1", mon_q.size());
        end else begin
            checks++; if (mon_q[0].fe !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", mon_q[0].fe); end
            checks++; if (mon_q[0].d !== 8'h00) begin errors++; $display("FAIL break_data: got %h want 00", mon_q[0].d); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic [3:0] sv;
            bit   pen, odd, pbit, exp_pe, exp_fe;
            int   ns, dv, nb, c0;
            rec_t r;
            dv   = $urandom_range(3, 24);
            d    = 8'($urandom);
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            ns   = $urandom_range(1, 4);
            sv   = 4'hF;
            for (int i = 0; i < ns; i++) if ($urandom_range(0, 3) == 0) sv[i] = 1'b0;
            pbit = (^d) ^ odd;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            exp_pe = pen && (pbit != ((^d) ^ odd));
            exp_fe = 1'b0;
            for (int i = 0; i < ns; i++) if (!sv[i]) exp_fe = 1'b1;
            nb = 9 + (pen ? 1 : 0) + ns;
            div = 16'(dv); parity = {pen, odd}; stop = 2'(ns - 1);
            mon_q.delete();
            fork
                send_frame(d, pen, pbit, ns, sv, dv, c0);
                begin
                    repeat (6) @(posedge clk);
                    #2;
                    div = 16'($urandom_range(3, 40)); parity = 2'($urandom); stop = 2'($urandom);
                end
            join
            rxd = 1'b1;
            repeat (2 * (dv + 1) + 4) @(posedge clk);
            #1;
            checks++;
            if (mon_q.size() != 1) begin
                errors++; $display("FAIL rand_count: frame %0d got %0d want 1", n, mon_q.size());
            end else begin
                r = mon_q.pop_front();
                checks++; if (r.d !== d) begin errors++; $display("FAIL rand_data: frame %0d got %h want %h", n, r.d, d); end
                checks++; if (r.pe !== exp_pe) begin errors++; $display("FAIL rand_perr: frame %0d got %b want %b", n, r.pe, exp_pe); end
                checks++; if (r.fe !== exp_fe) begin errors++; $display("FAIL rand_ferr: frame %0d got %b want %b", n, r.fe, exp_fe); end
                checks++; if (r.c != exp_cyc(c0, dv, nb)) begin errors++; $display("FAIL rand_latency: frame %0d got %0d want %0d", n, r.c, exp_cyc(c0, dv, nb)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rx_en();
        test_parity();
        test_odd_frame();
        test_glitch();
        test_spike();
        test_back_to_back();
        test_reset_mid();
        test_break();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
